// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle ARM core: fetch/decode/execute/memory/writeback sequencing.
// Optional performance counters (RetireCnt, StallCnt) are built when MULTICYCLE_PERF_EN is defined.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             LinkSel,
    output logic             PCS,
`ifdef MULTICYCLE_PERF_EN
    output logic [CNT_W-1:0] RetireCnt,
    output logic [CNT_W-1:0] StallCnt,
`endif
    output logic [3:0]       State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_LINK   = 4'd9,
        S_BRANCH = 4'd10
    } state_e;

    state_e state_q, state_d;

    logic mem_req_s, reg_w_s, mem_w_s, branch_s, link_sel_s;

    // Funct[4:1] belongs to the ALU decoder; CNT_W only matters with the counters built.
    logic unused_ok;
    assign unused_ok = ^{Funct[4:1], CNT_W[0]};

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_LINK;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_LINK:   state_d = S_BRANCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: reset is synchronous here, so it sits inside the clocked block rather than its sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of datapath selects and ungated strobes.
    always_comb begin
        mem_req_s  = 1'b0;
        reg_w_s    = 1'b0;
        mem_w_s    = 1'b0;
        branch_s   = 1'b0;
        link_sel_s = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w_s   = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s = 1'b1;
                mem_w_s   = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_EXECR: ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB: reg_w_s = 1'b1;
            S_LINK: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b11;
                ResultSrc  = 2'b10;
                reg_w_s    = 1'b1;
                link_sel_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are suppressed combinationally while reset is held low.
    assign MemReq  = reset & mem_req_s;
    assign IRWrite = reset & (state_q == S_FETCH) & MemReady;
    assign NextPC  = IRWrite;
    assign RegW    = reset & reg_w_s;
    assign MemW    = reset & mem_w_s;
    assign Branch  = reset & branch_s;
    assign LinkSel = reset & link_sel_s;
    assign PCS     = Branch | (RegW & (Rd == 4'hF));
    assign State   = state_q;

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] retire_q, stall_q;
    logic             retire_evt;

    assign retire_evt = (state_q == S_MEMWB || state_q == S_MEMWR ||
                         state_q == S_ALUWB || state_q == S_BRANCH) && (state_d == S_FETCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            if (retire_evt)          retire_q <= retire_q + CNT_W'(1);
            if (MemReq && !MemReady) stall_q  <= stall_q + CNT_W'(1);
        end
    end

    assign RetireCnt = retire_q;
    assign StallCnt  = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected state, a negedge monitor compares.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic       MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, LinkSel, PCS;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;
`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] RetireCnt, StallCnt;
`endif

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .MemReq(MemReq), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
        .RegW(RegW), .MemW(MemW), .Branch(Branch), .LinkSel(LinkSel), .PCS(PCS),
`ifdef MULTICYCLE_PERF_EN
        .RetireCnt(RetireCnt), .StallCnt(StallCnt),
`endif
        .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                           MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, LK = 4'd9, BR = 4'd10;

    typedef struct {
        logic [3:0] st;
        logic       rst;
        logic       mr;
        logic [3:0] rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected output table per state:
    // {MemReq,IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,LinkSel,PCS}
    function automatic logic [14:0] exp_outs(input exp_t e);
        logic mreq, irw, adr, srca, aop, rw, mw, br, ls;
        logic [1:0] srcb, res;
        {mreq, irw, adr, srca, aop, rw, mw, br, ls} = '0;
        srcb = 2'b00;
        res  = 2'b00;
        case (e.st)
            FE: begin mreq = 1; irw = e.mr; srca = 1; srcb = 2'b10; res = 2'b10; end
            DE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
            MA: srcb = 2'b01;
            MR: begin mreq = 1; adr = 1; end
            MB: begin res = 2'b01; rw = 1; end
            MW: begin mreq = 1; mw = 1; adr = 1; end
            ER: aop = 1;
            EI: begin srcb = 2'b01; aop = 1; end
            AW: rw = 1;
            LK: begin srca = 1; srcb = 2'b11; res = 2'b10; rw = 1; ls = 1; end
            BR: begin srcb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        if (!e.rst) {mreq, irw, rw, mw, br, ls} = '0;
        return {mreq, irw, irw, adr, srca, srcb, res, aop, rw, mw, br, ls,
                br | (rw & (e.rd == 4'hF))};
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("state", 32'(State), 32'(e.st));
                check($sformatf("outs_st%0d", e.st),
                      32'({MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                           ALUOp, RegW, MemW, Branch, LinkSel, PCS}),
                      32'(exp_outs(e)));
            end
        end
    end

    // One clock cycle: drive inputs, record expectation for this cycle, advance.
    task automatic step(input logic rst, input logic mr, input logic [3:0] st);
        exp_t e;
        reset    = rst;
        MemReady = mr;
        e.st = st; e.rst = rst; e.mr = mr; e.rd = Rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        Op = op; Funct = funct; Rd = rd;
    endtask

    initial begin
        reset = 1'b0; MemReady = 1'b0;
        instr(2'b10, 6'b000000, 4'd0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, FE);                 // strobes held off during reset even with ready

        // B with a 3-cycle fetch stall
        step(1'b1, 1'b0, FE);
        step(1'b1, 1'b0, FE);
        step(1'b1, 1'b0, FE);
        step(1'b1, 1'b1, FE);
        step(1'b1, 1'b1, DE);
        step(1'b1, 1'b1, BR);
`ifdef MULTICYCLE_PERF_EN
        check("stall_cnt", StallCnt, 32'd3);
        check("retire_cnt", RetireCnt, 32'd1);
`endif

        // ADDS register form, Rd=3 then Rd=15
        instr(2'b00, 6'b001001, 4'd3);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b0, ER); step(1'b1, 1'b1, AW);
        instr(2'b00, 6'b001001, 4'd15);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b0, DE); step(1'b1, 1'b1, ER); step(1'b1, 1'b0, AW);

        // immediate form and CMP (still passes through ALUWB)
        instr(2'b00, 6'b101001, 4'd2);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b1, EI); step(1'b1, 1'b1, AW);
        instr(2'b00, 6'b010101, 4'd15);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b0, ER); step(1'b1, 1'b1, AW);

        // LDR with two wait cycles in MEMRD
        instr(2'b01, 6'b011001, 4'd4);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b0, DE); step(1'b1, 1'b1, MA);
        step(1'b1, 1'b0, MR); step(1'b1, 1'b0, MR); step(1'b1, 1'b1, MR); step(1'b1, 1'b0, MB);

        // STR with one wait cycle; MemW held through it
        instr(2'b01, 6'b011000, 4'd5);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b1, MA);
        step(1'b1, 1'b0, MW); step(1'b1, 1'b1, MW);

        // BL
        instr(2'b11, 6'b000000, 4'd0);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b1, LK); step(1'b1, 1'b1, BR);

        // LDR aborted by a 2-cycle reset while waiting in MEMRD, then rerun cleanly
        instr(2'b01, 6'b011001, 4'd15);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b1, MA); step(1'b1, 1'b0, MR);
        step(1'b0, 1'b1, MR); step(1'b0, 1'b1, FE);
        step(1'b1, 1'b1, FE); step(1'b1, 1'b1, DE); step(1'b1, 1'b1, MA);
        step(1'b1, 1'b1, MR); step(1'b1, 1'b1, MB);
`ifdef MULTICYCLE_PERF_EN
        check("stall_cnt_after_rst", StallCnt, 32'd0);
        check("retire_cnt_after_rst", RetireCnt, 32'd1);
`endif
        step(1'b1, 1'b0, FE);

        done = 1'b1;
    end

    initial begin
        int budget;
        wait (done);
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
